// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the seven-segment encoder/decoder pair:
//   segment width, the 16 hex glyph patterns ([GFEDCBA], active-high)
//   and the frame decoder state encoding.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h67;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    // Entry i holds the glyph for hex digit i.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/seg_pattern_to_nibble.sv
// seg_pattern_to_nibble
//   Combinational inverse of the hex-to-seven-segment encoder.
//   Ports:
//     seg          in   SEG_W  segment pattern [GFEDCBA]
//     nibble       out  4      decoded hex digit (0 when undecodable)
//     undecodable  out  1      pattern is not an exact glyph match
module seg_pattern_to_nibble
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             undecodable
);

    always_comb begin
        nibble      = '0;
        undecodable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                nibble      = 4'(i);
                undecodable = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_frame_decoder.sv
// seven_seg_frame_decoder
//   Sniffs a multiplexed seven-segment bus and rebuilds the displayed hex
//   frame. Each digit must be stable for STABLE_CYCLES registered samples
//   before it is accepted; digits must arrive in scan order 0..NUM_DIGITS-1.
//   Ports:
//     i_clk        in   1             clock, rising edge
//     i_rst        in   1             synchronous active-high reset
//     i_segments   in   SEG_W         segment pattern [GFEDCBA]
//     i_digit_sel  in   NUM_DIGITS    one-hot digit strobe, bit 0 first
//     o_value      out  4*NUM_DIGITS  last completed frame, digit k at [4k+3:4k]
//     o_valid      out  1             one-cycle pulse when o_value/o_error update
//     o_error      out  1             last frame held an undecodable pattern
module seven_seg_frame_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SEG_W-1:0]        i_segments,
    input  logic [NUM_DIGITS-1:0]   i_digit_sel,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic                    o_valid,
    output logic                    o_error
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Registered sample pair and the pair from the cycle before.
    logic [NUM_DIGITS-1:0]   sel_q, sel_prev;
    logic [SEG_W-1:0]        seg_q, seg_prev;
    logic [CNT_W-1:0]        cnt_q, cnt_eff;
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
    logic                    err_q, err_d;

    logic                    changed, capture_ok;
    logic                    strobe, blank, glitch, first;
    logic [NUM_DIGITS-1:0]   exp_mask, next_mask;
    logic [3:0]              nibble;
    logic                    undec;
    logic                    enter, cap, publish;
    logic [IDX_W-1:0]        enter_idx, cap_idx;

    seg_pattern_to_nibble u_lookup (
        .seg         (seg_q),
        .nibble      (nibble),
        .undecodable (undec)
    );

    assign changed    = (sel_q != sel_prev) || (seg_q != seg_prev);
    // Count for the current sample, so a fresh pair counts as 1 on the
    // cycle it is first seen.
    assign cnt_eff    = changed ? CNT_W'(1)
                      : (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    assign capture_ok = (cnt_eff == CNT_MAX);

    assign blank     = (sel_q == '0);
    assign strobe    = !blank && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
    assign glitch    = !blank && !strobe;
    assign first     = (sel_q == NUM_DIGITS'(1));
    assign exp_mask  = NUM_DIGITS'(1) << idx_q;
    // Shifts out past the last digit, so it never matches a strobe there.
    assign next_mask = exp_mask << 1;

    always_comb begin
        frame_d = frame_q >> 4;
        frame_d[4*NUM_DIGITS-1 -: 4] = nibble;
    end
    assign err_d = undec | ((cap_idx != '0) && err_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        enter     = 1'b0;
        enter_idx = '0;
        cap       = 1'b0;
        cap_idx   = idx_q;
        publish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (first) enter = 1'b1;
            end
            S_SETTLE: begin
                if (glitch) begin
                    state_d = S_IDLE;
                end else if (!changed) begin
                    if (capture_ok) cap = 1'b1;
                end else if (first) begin
                    enter = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (glitch) begin
                    state_d = S_IDLE;
                end else if (blank || !changed || sel_q == exp_mask) begin
                    state_d = S_HOLD;  // late segment changes on the same strobe are ignored
                end else if (sel_q == next_mask) begin
                    enter     = 1'b1;
                    enter_idx = idx_q + 1'b1;
                end else if (first) begin
                    enter = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Entering a digit whose count is already complete (always the
        // case with STABLE_CYCLES=1) captures on the same edge.
        if (enter) begin
            if (capture_ok) begin
                cap     = 1'b1;
                cap_idx = enter_idx;
            end else begin
                state_d = S_SETTLE;
                idx_d   = enter_idx;
            end
        end

        if (cap) begin
            if (cap_idx == LAST_IDX) begin
                state_d = S_IDLE;
                publish = 1'b1;
            end else begin
                state_d = S_HOLD;
                idx_d   = cap_idx;
            end
        end

        if (state_d == S_IDLE) idx_d = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_q    <= '0;
            seg_q    <= '0;
            sel_prev <= '0;
            seg_prev <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            err_q    <= 1'b0;
            o_value  <= '0;
            o_valid  <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            sel_q    <= i_digit_sel;
            seg_q    <= i_segments;
            sel_prev <= sel_q;
            seg_prev <= seg_q;
            cnt_q    <= cnt_eff;
            o_valid  <= publish;
            if (cap) begin
                frame_q <= frame_d;
                err_q   <= err_d;
            end
            if (publish) begin
                o_value <= frame_d;
                o_error <= err_d;
            end
        end
    end

endmodule
